// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
package mips_pkg;

    localparam int MIPS_ADDR_W = 32;
    localparam int MIPS_DATA_W = 32;

    localparam logic [MIPS_DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [MIPS_ADDR_W-1:0] pc;
        logic [MIPS_DATA_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/mips_fetch_queue.sv
// Prefetch FIFO of {pc, instr} entries; flush wins over push and pop.
module mips_fetch_queue
    import mips_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    input  logic                     flush,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop && (count_reg != '0);
    // A push into a full queue is only legal when the head leaves on the same edge.
    assign do_push = push && ((count_reg != FULL) || do_pop);

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Fetch front end: owns the fetch PC, talks req/ack to instruction memory,
// and feeds IF/ID from a prefetch queue; redirects flush and drop in-flight data.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = MIPS_ADDR_W,
    parameter int                DATA_W   = MIPS_DATA_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pc_plus4
);

    localparam int                CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    fetch_state_t      state_reg;
    logic [ADDR_W-1:0] fetch_pc_reg;
    logic [ADDR_W-1:0] hold_addr_reg;
    logic [ADDR_W-1:0] last_pc_reg;
    logic [DATA_W-1:0] last_instr_reg;

    logic [CW-1:0]     q_count;
    entry_t            q_head;
    entry_t            push_entry;
    logic              q_empty;
    logic              accept;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] redirect_aligned;

    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
    assign q_empty          = (q_count == '0);

    // Only one request is ever in flight, so count < DEPTH leaves room for its data.
    assign imem_req  = !rst && ((state_reg == DISCARD) || (q_count < DEPTH_C));
    assign imem_addr = (state_reg == DISCARD) ? hold_addr_reg : fetch_pc_reg;

    assign accept     = (state_reg == FETCH) && imem_req && imem_ack;
    assign push       = accept && !redirect;
    assign pop        = out_valid && out_ready;
    assign push_entry = '{pc: fetch_pc_reg, instr: imem_rdata};

    mips_fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .head      (q_head),
        .count     (q_count)
    );

    // When the queue drains, the last head stays visible on the outputs.
    assign out_valid    = !q_empty;
    assign out_pc       = q_empty ? last_pc_reg    : q_head.pc;
    assign out_instr    = q_empty ? last_instr_reg : q_head.instr;
    assign out_pc_plus4 = out_pc + PC_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= FETCH;
            fetch_pc_reg   <= RESET_PC;
            hold_addr_reg  <= RESET_PC;
            last_pc_reg    <= '0;
            last_instr_reg <= DATA_W'(NOP_INSTR);
        end else begin
            if (!q_empty) begin
                last_pc_reg    <= q_head.pc;
                last_instr_reg <= q_head.instr;
            end
            unique case (state_reg)
                FETCH: begin
                    if (redirect) begin
                        fetch_pc_reg <= redirect_aligned;
                        // A request still waiting for its ack cannot be withdrawn.
                        if (imem_req && !imem_ack) begin
                            state_reg     <= DISCARD;
                            hold_addr_reg <= fetch_pc_reg;
                        end
                    end else if (accept) begin
                        fetch_pc_reg <= fetch_pc_reg + PC_STEP;
                    end
                end
                DISCARD: begin
                    if (redirect) begin
                        fetch_pc_reg <= redirect_aligned;
                    end
                    if (imem_ack) begin
                        state_reg <= FETCH;
                    end
                end
                default: state_reg <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Cycle-by-cycle directed vectors for mips_fetch_unit with a scripted-ack memory.
module tb_mips_fetch_unit;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic        rst;
        logic        ack;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl [29];

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h8C00_0000;
    endfunction

    // Memory contents are a fixed function of the word address.
    assign imem_rdata = instr_of(imem_addr);

    mips_fetch_unit #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        rst         = v.rst;
        imem_ack    = v.ack;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        out_ready   = v.rdy;
        #1;
        $display("%s: rst=%b ack=%b redir=%b rdy=%b | req=%b addr=%h valid=%b pc=%h instr=%h",
                 tag, rst, imem_ack, redirect, out_ready, imem_req, imem_addr, out_valid, out_pc, out_instr);
        check({tag, " req"}, {31'h0, imem_req}, {31'h0, v.exp_req});
        check({tag, " addr"}, imem_addr, v.exp_addr);
        check({tag, " valid"}, {31'h0, out_valid}, {31'h0, v.exp_valid});
        check({tag, " pc"}, out_pc, v.exp_pc);
        check({tag, " pc_plus4"}, out_pc_plus4, v.exp_pc + 32'd4);
        if (v.exp_valid)
            check({tag, " instr"}, out_instr, instr_of(v.exp_pc));
        else if (v.rst && v.exp_pc == 32'h0)
            check({tag, " instr_rst"}, out_instr, 32'h0);
    endtask

    initial begin
        //           rst ack red rpc           rdy  req addr          vld pc
        // zero-latency streaming with out_ready high
        tbl[0]  = '{T, F, F, 32'h0,        F,   F, 32'h0,        F, 32'h0};
        tbl[1]  = '{F, T, F, 32'h0,        T,   T, 32'h0,        F, 32'h0};
        tbl[2]  = '{F, T, F, 32'h0,        T,   T, 32'h4,        T, 32'h0};
        tbl[3]  = '{F, T, F, 32'h0,        T,   T, 32'h8,        T, 32'h4};
        tbl[4]  = '{F, T, F, 32'h0,        T,   T, 32'hC,        T, 32'h8};
        tbl[5]  = '{F, F, F, 32'h0,        T,   T, 32'h10,       T, 32'hC};
        // stall fills exactly DEPTH entries, then drains in order
        tbl[6]  = '{T, F, F, 32'h0,        F,   F, 32'h10,       F, 32'hC};
        tbl[7]  = '{T, F, F, 32'h0,        F,   F, 32'h0,        F, 32'h0};
        tbl[8]  = '{F, T, F, 32'h0,        F,   T, 32'h0,        F, 32'h0};
        tbl[9]  = '{F, T, F, 32'h0,        F,   T, 32'h4,        T, 32'h0};
        tbl[10] = '{F, T, F, 32'h0,        F,   T, 32'h8,        T, 32'h0};
        tbl[11] = '{F, T, F, 32'h0,        F,   T, 32'hC,        T, 32'h0};
        tbl[12] = '{F, F, F, 32'h0,        F,   F, 32'h10,       T, 32'h0};
        tbl[13] = '{F, F, F, 32'h0,        T,   F, 32'h10,       T, 32'h0};
        tbl[14] = '{F, F, F, 32'h0,        T,   T, 32'h10,       T, 32'h4};
        tbl[15] = '{F, T, F, 32'h0,        T,   T, 32'h10,       T, 32'h8};
        tbl[16] = '{F, F, F, 32'h0,        T,   T, 32'h14,       T, 32'hC};
        tbl[17] = '{F, F, F, 32'h0,        T,   T, 32'h14,       T, 32'h10};
        tbl[18] = '{F, F, F, 32'h0,        F,   T, 32'h14,       F, 32'h10};
        // redirect (misaligned target) coinciding with an ack and a pop
        tbl[19] = '{T, F, F, 32'h0,        F,   F, 32'h14,       F, 32'h10};
        tbl[20] = '{T, F, F, 32'h0,        F,   F, 32'h0,        F, 32'h0};
        tbl[21] = '{F, T, F, 32'h0,        F,   T, 32'h0,        F, 32'h0};
        tbl[22] = '{F, T, F, 32'h0,        F,   T, 32'h4,        T, 32'h0};
        tbl[23] = '{F, T, F, 32'h0,        F,   T, 32'h8,        T, 32'h0};
        tbl[24] = '{F, T, T, 32'h43,       T,   T, 32'hC,        T, 32'h0};
        tbl[25] = '{F, F, F, 32'h0,        T,   T, 32'h40,       F, 32'h0};
        tbl[26] = '{F, T, F, 32'h0,        T,   T, 32'h40,       F, 32'h0};
        tbl[27] = '{F, F, F, 32'h0,        T,   T, 32'h44,       T, 32'h40};
        tbl[28] = '{F, F, F, 32'h0,        F,   T, 32'h44,       F, 32'h40};

        for (int i = 0; i < 29; i++) begin
            run_vec(tbl[i], $sformatf("tbl[%0d]", i));
        end

        // Slow memory: redirects while the request for 0x8 is outstanding
        run_vec('{T, F, F, 32'h0,        F,   F, 32'h44,       F, 32'h40}, "slow0");
        run_vec('{T, F, F, 32'h0,        F,   F, 32'h0,        F, 32'h0},  "slow1");
        run_vec('{F, T, F, 32'h0,        T,   T, 32'h0,        F, 32'h0},  "slow2");
        run_vec('{F, T, F, 32'h0,        T,   T, 32'h4,        T, 32'h0},  "slow3");
        run_vec('{F, F, F, 32'h0,        T,   T, 32'h8,        T, 32'h4},  "slow4");
        run_vec('{F, F, T, 32'h80,       T,   T, 32'h8,        F, 32'h4},  "slow5");
        run_vec('{F, F, T, 32'h100,      T,   T, 32'h8,        F, 32'h4},  "slow6");
        run_vec('{F, T, F, 32'h0,        T,   T, 32'h8,        F, 32'h4},  "slow7");
        run_vec('{F, F, F, 32'h0,        T,   T, 32'h100,      F, 32'h4},  "slow8");
        run_vec('{F, F, F, 32'h0,        T,   T, 32'h100,      F, 32'h4},  "slow9");
        run_vec('{F, T, F, 32'h0,        F,   T, 32'h100,      F, 32'h4},  "slow10");
        run_vec('{F, F, F, 32'h0,        F,   T, 32'h104,      T, 32'h100}, "slow11");

        // Address wrap at the top of the space, then reset mid-request
        run_vec('{F, F, T, 32'hFFFF_FFFC, T,  T, 32'h104,      T, 32'h100}, "wrap0");
        run_vec('{F, T, F, 32'h0,        T,   T, 32'h104,      F, 32'h100}, "wrap1");
        run_vec('{F, T, F, 32'h0,        F,   T, 32'hFFFF_FFFC, F, 32'h100}, "wrap2");
        run_vec('{F, F, F, 32'h0,        F,   T, 32'h0,        T, 32'hFFFF_FFFC}, "wrap3");
        run_vec('{T, F, F, 32'h0,        F,   F, 32'h0,        T, 32'hFFFF_FFFC}, "rstmid0");
        run_vec('{T, F, F, 32'h0,        F,   F, 32'h0,        F, 32'h0},  "rstmid1");
        run_vec('{F, F, F, 32'h0,        F,   T, 32'h0,        F, 32'h0},  "rstmid2");
        run_vec('{F, T, F, 32'h0,        F,   T, 32'h0,        F, 32'h0},  "rstmid3");
        run_vec('{F, F, F, 32'h0,        F,   T, 32'h4,        T, 32'h0},  "rstmid4");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Instruction-fetch front end of the pipelined MIPS core. It sits directly upstream of the IF/ID register in `datapath`.
- Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake that tolerates variable latency.
- Buffers returned words with their PCs in a small prefetch queue and presents them to IF/ID with a valid/ready handshake.
- Accepts branch/jump redirects; a redirect flushes the queue and discards in-flight fetches.

Parameters:
- ADDR_W, 32, width of PC and instruction address.
- DATA_W, 32, instruction word width.
- DEPTH, 4, prefetch queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  read request; held until imem_ack.
- imem_addr  output  ADDR_W  word-aligned fetch address; stable while imem_req is high.
- imem_ack  input  1  one-cycle pulse completing the current request; may arrive in the same cycle as imem_req.
- imem_rdata  input  DATA_W  instruction word; valid when imem_ack is high.
- redirect  input  1  branch/jump taken or flush from the controller.
- redirect_pc  input  ADDR_W  new fetch target; valid when redirect is high.
- out_ready  input  1  IF/ID load enable (the pipeline's PC_load); low means stall.
- out_valid  output  1  queue head holds a valid instruction.
- out_instr  output  DATA_W  head instruction.
- out_pc  output  ADDR_W  PC of the head instruction.
- out_pc_plus4  output  ADDR_W  out_pc + 4, used for link/branch base.

Behaviour:
- Reset state:
  - All state clears synchronously while rst is high.
  - Outputs during reset: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=4.
  - Queue is emptied, fetch PC is set to RESET_PC, FSM enters FETCH.
- FSM states:
  - FETCH:
    - imem_req = (count + pending < DEPTH).
    - pending is 1 while a request is outstanding.
  - DISCARD:
    - imem_req stays high at the old address until imem_ack, because a request is never withdrawn.
    - That ack's data is dropped; the FSM then returns to FETCH at the redirected PC.
- Fetch PC:
  - On each accepted ack in FETCH, the {pc, rdata} pair is enqueued and the fetch PC advances by 4, modulo 2^ADDR_W; wrap is allowed.
  - imem_addr updates on the next cycle.
  - imem_req may stay high continuously, giving 1 instr/cycle with a zero-latency memory.
- Latency:
  - An ack at edge N makes out_valid high after edge N (cycle N+1) when the queue was empty.
  - The first instruction after reset appears 1 cycle after the first ack.
- Dequeue:
  - out_valid && out_ready pops the head at the edge.
  - Head outputs come from queue registers; they are not combinational from imem_rdata.
- Full queue: no request is issued when count + pending == DEPTH, so an ack never overflows the queue. A pop in the same cycle as an ack is legal.
- Empty queue: out_valid=0; out_instr/out_pc hold their last values; out_ready is ignored.
- Redirect (highest priority):
  - At the edge with redirect=1:
    - queue is cleared;
    - any pop in that cycle is cancelled (IF/ID is flushed by the controller);
    - fetch PC is set to redirect_pc.
  - If a request is outstanding and not acked in this cycle, the FSM goes to DISCARD.
  - If imem_ack coincides with redirect, that data is dropped and the FSM stays in FETCH.
  - redirect_pc is issued as imem_addr on the next cycle at the earliest.
- Redirect in DISCARD: fetch PC is updated to the newest redirect_pc; the FSM stays in DISCARD.
- Reset mid-request: the request is abandoned. The memory model is also reset by rst.
- redirect_pc[1:0] != 0 is forced to 0; a misaligned target is not an exception source.

Decomposition:
- Package mips_pkg:
  - ADDR_W/DATA_W defaults.
  - NOP_INSTR = 32'h0000_0000.
  - typedef fetch_entry_t {pc, instr}.
  - fetch FSM state enum {FETCH, DISCARD}.
- Sub-module mips_fetch_queue: synchronous FIFO of fetch_entry_t with push/pop/flush and count output; flush has priority over push and pop.
- The FSM and PC logic remain in mips_fetch_unit.

Test Plan:
- Release reset; memory acks in the same cycle; out_ready=1 → imem_addr 0,4,8,C on consecutive cycles; out_pc sequence 0,4,8 starting 1 cycle after the first ack; out_pc_plus4 = out_pc + 4.
- out_ready=0 with DEPTH=4 and zero-latency memory → exactly 4 acks, then imem_req=0. Raise out_ready → pops of PCs 0,4,8,C in order and fetching resumes at 0x10.
- Memory with 3-cycle ack latency; redirect to 0x100 one cycle after req for 0x8 → req held at 0x8 until ack, data discarded, next imem_addr=0x100, first out_pc=0x100.
- redirect to 0x40 in the same cycle as an ack for 0xC and a pop → 0xC never appears, queue empty next cycle, out_valid=0, imem_addr=0x40 next cycle.
- Fetch PC 0xFFFF_FFFC acked → next imem_addr=0x0000_0000 (wrap).
- Assert rst while a request is outstanding and the queue is non-empty → next cycle out_valid=0, imem_req=0; first fetch after release is RESET_PC.
